// File: rtl/cs_sample_feeder.sv
// cs_sample_feeder
//   Transmit-side feeder for a WIN-tap sliding-window smoothing filter.
//   Upstream samples arrive over a valid/ready handshake and are buffered in a
//   FIFO. Once enough samples are buffered, the FIFO is drained at exactly one
//   sample per clock onto X, because the filter shifts its window every edge.
//   y_valid flags the filter output cycles whose window holds WIN fresh,
//   contiguous frame samples.
//
// Ports
//   clk       in   1  clock, rising edge
//   reset     in   1  synchronous, active-low reset
//   in_valid  in   1  upstream sample valid
//   in_data   in   8  upstream sample
//   in_last   in   1  marks in_data as the last sample of a frame
//   in_ready  out  1  FIFO can accept a sample (occupancy < DEPTH)
//   X         out  8  sample driven to the filter
//   x_valid   out  1  X carries a real frame sample this cycle
//   y_valid   out  1  filter Y this cycle covers WIN fresh samples
//   underrun  out  1  sticky: FIFO ran dry in the middle of a frame
//   busy      out  1  feeder is not idle
module cs_sample_feeder #(
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 4,
  parameter int WIN       = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] X,
  output logic       x_valid,
  output logic       y_valid,
  output logic       underrun,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_UNDERRUN
  } state_t;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_lastCnt;
  state_t        r_state;
  logic [7:0]    r_x;
  logic          r_xValid;
  logic          r_yValid;
  logic          r_underrun;
  logic [WW-1:0] r_winCnt;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [8:0]    w_head;
  logic          w_enough;
  logic          w_enterUnderrun;
  logic          w_winFull;

  // Occupancy-based handshake. Reset gates the push so nothing offered
  // while reset is held ever lands in the FIFO.
  assign w_ready  = (r_count < CW'(DEPTH));
  assign w_push   = reset && in_valid && w_ready;
  assign w_pop    = (r_state == ST_STREAM) && (r_count != '0);
  assign w_head   = r_mem[r_rdPtr];

  // Streaming may (re)start with a full priming level, or earlier when a
  // frame end is already buffered, so short frames are never stuck.
  assign w_enough = (r_count >= CW'(PRIME_LVL)) || (r_lastCnt != '0);

  assign w_enterUnderrun = (r_state == ST_STREAM) && !w_pop;
  assign w_winFull       = (r_winCnt >= WW'(WIN - 1));

  assign in_ready = w_ready;
  assign X        = r_x;
  assign x_valid  = r_xValid;
  assign y_valid  = r_yValid;
  assign underrun = r_underrun;
  assign busy     = (r_state != ST_IDLE);

  // Storage array. Contents need no reset: the pointers and occupancy
  // define what is valid, so clearing those discards everything.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {in_last, in_data};
    end
  end

  // Pointers, occupancy and a count of buffered frame ends. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_lastCnt <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_lastCnt <= r_lastCnt + CW'(w_push && in_last) - CW'(w_pop && w_head[8]);
    end
  end

  // Feeder state machine with registered X/x_valid/underrun. Popping the
  // frame's last entry moves straight to IDLE while that sample is still
  // on X, which guarantees at least one x_valid=0 gap between frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_x        <= '0;
      r_xValid   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_x      <= '0;
          r_xValid <= 1'b0;
          if (r_count != '0) begin
            r_state <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          r_x      <= '0;
          r_xValid <= 1'b0;
          if (w_enough) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_pop) begin
            r_x      <= w_head[7:0];
            r_xValid <= 1'b1;
            if (w_head[8]) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_xValid   <= 1'b0;
            r_underrun <= 1'b1;
            r_state    <= ST_UNDERRUN;
          end
        end
        ST_UNDERRUN: begin
          r_xValid   <= 1'b0;
          r_underrun <= 1'b1;
          if (w_enough) begin
            r_state <= ST_STREAM;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Window tracking. r_winCnt counts the contiguous x_valid cycles before
  // the current one; y_valid is registered one edge later to line up with
  // the filter registering the sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_winCnt <= '0;
      r_yValid <= 1'b0;
    end else begin
      r_yValid <= r_xValid && w_winFull;
      if (!r_xValid || w_enterUnderrun) begin
        r_winCnt <= '0;
      end else if (r_winCnt != WW'(WIN)) begin
        r_winCnt <= r_winCnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cs_sample_feeder.sv
// Self-checking bench for cs_sample_feeder: a reset/short-frame vector table,
// directed multi-cycle sequences, and randomized traffic, all compared every
// cycle against a queue-based behavioural model of the feeder.
module tb_cs_sample_feeder;

  localparam int DEPTH     = 16;
  localparam int PRIME_LVL = 4;
  localparam int WIN       = 9;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic [7:0] inData;
  logic       inLast;
  logic       inReady;
  logic [7:0] xOut;
  logic       xValid;
  logic       yValid;
  logic       underrunOut;
  logic       busyOut;

  logic       fReset;
  logic       fValid;
  logic [7:0] fData;
  logic       fLast;
  logic       fReady;
  logic [7:0] fX;
  logic       fXv;
  logic       fYv;
  logic       fUnder;
  logic       fBusy;

  int checks;
  int errors;

  cs_sample_feeder #(.DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL), .WIN(WIN)) uDut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData),
    .in_last(inLast), .in_ready(inReady), .X(xOut), .x_valid(xValid),
    .y_valid(yValid), .underrun(underrunOut), .busy(busyOut)
  );

  cs_sample_feeder #(.DEPTH(DEPTH), .PRIME_LVL(DEPTH), .WIN(WIN)) uFull (
    .clk(clk), .reset(fReset), .in_valid(fValid), .in_data(fData),
    .in_last(fLast), .in_ready(fReady), .X(fX), .x_valid(fXv),
    .y_valid(fYv), .underrun(fUnder), .busy(fBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the FIFO is a queue of {last,data}; mMode is the
  // feeder activity (0 idle, 1 priming, 2 streaming, 3 starved); mRun is the
  // length of the current run of valid samples including this cycle.
  logic [8:0] mq[$];
  int         mMode;
  logic [7:0] mX;
  bit         mXv;
  bit         mYv;
  bit         mUnder;
  int         mRun;

  task automatic modelStep(input bit rst, input bit v, input logic [7:0] d, input bit l);
    bit push;
    bit lastIn;
    bit enough;
    logic [8:0] e;
    if (!rst) begin
      mq.delete();
      mMode = 0; mX = 8'h00; mXv = 0; mYv = 0; mUnder = 0; mRun = 0;
      return;
    end
    push   = v && (mq.size() < DEPTH);
    lastIn = 0;
    foreach (mq[k]) if (mq[k][8]) lastIn = 1;
    enough = (mq.size() >= PRIME_LVL) || lastIn;
    mYv = mXv && (mRun >= WIN);
    case (mMode)
      0: begin mX = 8'h00; mXv = 0; if (mq.size() > 0) mMode = 1; end
      1: begin mX = 8'h00; mXv = 0; if (enough) mMode = 2; end
      2: begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          mX = e[7:0]; mXv = 1;
          if (e[8]) mMode = 0;
        end else begin
          mXv = 0; mUnder = 1; mMode = 3;
        end
      end
      default: begin mXv = 0; mUnder = 1; if (enough) mMode = 2; end
    endcase
    if (push) mq.push_back({l, d});
    mRun = mXv ? mRun + 1 : 0;
  endtask

  task automatic checkVal(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", nm, actual, expected);
    end
  endtask

  task automatic checkOutput(input string nm);
    checkVal({nm, ".X"}, 32'(xOut), 32'(mX));
    checkVal({nm, ".x_valid"}, 32'(xValid), 32'(mXv));
    checkVal({nm, ".y_valid"}, 32'(yValid), 32'(mYv));
    checkVal({nm, ".underrun"}, 32'(underrunOut), 32'(mUnder));
    checkVal({nm, ".busy"}, 32'(busyOut), 32'(mMode != 0));
    checkVal({nm, ".in_ready"}, 32'(inReady), 32'(mq.size() < DEPTH));
  endtask

  // Observation of the main DUT stream for directed sequence checks.
  int         obsX[$];
  int         obsY;
  int         firstYPrevX;
  int         prevX;

  task automatic clearObs();
    obsX.delete();
    obsY = 0;
    firstYPrevX = -1;
    prevX = -1;
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d, input bit l, input string nm);
    reset = rst; inValid = v; inData = d; inLast = l;
    modelStep(rst, v, d, l);
    @(posedge clk);
    @(negedge clk);
    checkOutput(nm);
    if (xValid) obsX.push_back(int'(xOut));
    if (yValid) begin
      if (obsY == 0) firstYPrevX = prevX;
      obsY++;
    end
    prevX = xValid ? int'(xOut) : -1;
  endtask

  task automatic pushSeq(input int n, input int base, input int stepv, input bit withLast, input string nm);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 1, 8'(base + i * stepv), withLast && (i == n - 1), nm);
    end
  endtask

  task automatic idleCycles(input int n, input string nm);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, 0, nm);
  endtask

  task automatic checkSeq(input string nm, input int base, input int stepv, input int n);
    checkVal({nm, ".count"}, 32'(obsX.size()), 32'(n));
    for (int i = 0; i < n && i < obsX.size(); i++) begin
      checkVal($sformatf("%s.X[%0d]", nm, i), 32'(obsX[i]), 32'(base + i * stepv));
    end
  endtask

  typedef struct {
    bit         rst;
    bit         v;
    logic [7:0] d;
    bit         l;
    logic [7:0] eX;
    bit         eXv;
    bit         eYv;
    bit         eBusy;
    bit         eReady;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;
    int stallAt;
    int outAtStall;
    bit acc;
    bit found;
    int fOut[$];

    // Reset held with in_valid high, then a 3-sample short frame.
    tbl[0]  = '{0, 1, 8'h11, 0, 8'h00, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 8'h12, 0, 8'h00, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 8'h13, 0, 8'h00, 0, 0, 0, 1};
    tbl[3]  = '{1, 1, 8'h01, 0, 8'h00, 0, 0, 0, 1};
    tbl[4]  = '{1, 1, 8'h02, 0, 8'h00, 0, 0, 1, 1};
    tbl[5]  = '{1, 1, 8'h03, 1, 8'h00, 0, 0, 1, 1};
    tbl[6]  = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1};
    tbl[7]  = '{1, 0, 8'h00, 0, 8'h01, 1, 0, 1, 1};
    tbl[8]  = '{1, 0, 8'h00, 0, 8'h02, 1, 0, 1, 1};
    tbl[9]  = '{1, 0, 8'h00, 0, 8'h03, 1, 0, 0, 1};
    tbl[10] = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1};
    tbl[11] = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1};

    checks = 0; errors = 0;
    reset = 0; inValid = 0; inData = 0; inLast = 0;
    fReset = 0; fValid = 0; fData = 0; fLast = 0;
    mq.delete(); mMode = 0; mX = 0; mXv = 0; mYv = 0; mUnder = 0; mRun = 0;
    clearObs();
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      applyStimulus(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].l, nm);
      checkVal({nm, ".tX"}, 32'(xOut), 32'(tbl[i].eX));
      checkVal({nm, ".tXv"}, 32'(xValid), 32'(tbl[i].eXv));
      checkVal({nm, ".tYv"}, 32'(yValid), 32'(tbl[i].eYv));
      checkVal({nm, ".tBusy"}, 32'(busyOut), 32'(tbl[i].eBusy));
      checkVal({nm, ".tReady"}, 32'(inReady), 32'(tbl[i].eReady));
    end

    // 12-sample frame 10..120 pushed back to back.
    clearObs();
    pushSeq(12, 10, 10, 1, "frame12");
    idleCycles(12, "frame12");
    checkSeq("frame12", 10, 10, 12);
    checkVal("frame12.yCount", 32'(obsY), 32'd4);
    checkVal("frame12.yStartAfterX", 32'(firstYPrevX), 32'd90);
    checkVal("frame12.busyEnd", 32'(busyOut), 32'd0);

    // Reset in the middle of a stream, then a fresh 9-sample frame.
    clearObs();
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(1, 1, 8'(30 + i), i == 11, "rstmid");
      if (xValid && xOut == 8'd36) found = 1;
    end
    checkVal("rstmid.reachSample7", 32'(found), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, "rstmid.rst");
    checkVal("rstmid.xValid", 32'(xValid), 32'd0);
    checkVal("rstmid.busy", 32'(busyOut), 32'd0);
    checkVal("rstmid.ready", 32'(inReady), 32'd1);
    clearObs();
    pushSeq(9, 200, 1, 1, "fresh9");
    idleCycles(14, "fresh9");
    checkSeq("fresh9", 200, 1, 9);
    checkVal("fresh9.yCount", 32'(obsY), 32'd1);

    // Underrun: 5 samples, 6-cycle stall, then 10 more ending the frame.
    clearObs();
    pushSeq(5, 1, 1, 0, "under");
    idleCycles(6, "under");
    checkVal("under.xValidStalled", 32'(xValid), 32'd0);
    checkVal("under.xHeld", 32'(xOut), 32'd5);
    checkVal("under.flag", 32'(underrunOut), 32'd1);
    pushSeq(10, 6, 1, 1, "under");
    idleCycles(16, "under");
    checkSeq("under", 1, 1, 15);
    checkVal("under.yCount", 32'(obsY), 32'd2);
    checkVal("under.sticky", 32'(underrunOut), 32'd1);

    // Randomized traffic, with the valid density varied per block so both
    // streaming and starvation occur, plus occasional resets.
    for (int blk = 0; blk < 10; blk++) begin
      int p;
      p = $urandom_range(1, 4);
      for (int c = 0; c < 50; c++) begin
        applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) < p,
                      8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0, "rand");
      end
    end
    idleCycles(40, "rand");

    // Fill a FIFO whose consumer only starts at full occupancy.
    fReset = 1;
    @(negedge clk);
    checkVal("full.readyAfterReset", 32'(fReady), 32'd1);
    sent = 0; stallAt = -1; outAtStall = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      fValid = (sent < 20);
      fData  = 8'(sent + 1);
      fLast  = (sent == 19);
      acc    = fValid && fReady;
      if (fValid && !fReady && stallAt < 0) begin
        stallAt = sent;
        outAtStall = fOut.size();
      end
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
      if (fXv) fOut.push_back(int'(fX));
      if (fOut.size() >= 20 && !fBusy) break;
    end
    fValid = 0;
    checkVal("full.acceptedAtStall", 32'(stallAt), 32'd16);
    checkVal("full.noOutputBeforeStall", 32'(outAtStall), 32'd0);
    checkVal("full.count", 32'(fOut.size()), 32'd20);
    for (int i = 0; i < 20 && i < fOut.size(); i++) begin
      checkVal($sformatf("full.X[%0d]", i), 32'(fOut[i]), 32'(i + 1));
    end
    checkVal("full.underrun", 32'(fUnder), 32'd0);
    checkVal("full.busyEnd", 32'(fBusy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_sample_feeder.md
Name: cs_sample_feeder

Overview:
- Transmit-side partner of the 9-tap sliding-window smoothing filter (ports X/Y).
- Accepts 8-bit samples from an upstream producer over a valid/ready handshake and buffers them in a FIFO.
- Drives the filter's X input with exactly one sample per clock, because the filter shifts its window on every edge.
- Marks which filter Y cycles come from a window of 9 fresh, contiguous frame samples.

Parameters:
DEPTH, 16, FIFO entries (power of 2, min 4)
PRIME_LVL, 4, FIFO occupancy required before streaming starts (1..DEPTH)
WIN, 9, filter window length; Y is trusted after WIN contiguous samples

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  upstream sample valid
in_data  in  8  upstream sample
in_last  in  1  qualifies in_data as last sample of frame
in_ready  out  1  FIFO can accept (occupancy < DEPTH)
X  out  8  sample to filter
x_valid  out  1  X carries a real frame sample this cycle
y_valid  out  1  filter Y this cycle covers WIN fresh samples
underrun  out  1  sticky: FIFO emptied mid-frame
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at posedge): FIFO empty; state IDLE; X=0; x_valid=0; y_valid=0; underrun=0; win_cnt=0. in_ready=1 in the cycle after reset releases.
- Write: a push occurs when in_valid && in_ready. The FIFO stores {in_last, in_data}, 9 bits per entry.
- in_ready is combinational from occupancy. Push and pop in the same cycle when full is allowed only if in_ready was 1 (i.e. not full), so there is no bypass.
- States:
  - IDLE: X=0, x_valid=0. Go to PRIME when occupancy>0.
  - PRIME: hold X=0, x_valid=0. Go to STREAM when occupancy>=PRIME_LVL, or when an entry with last=1 is present (short frame).
  - STREAM: pop one entry per cycle. X and x_valid are registered, so an entry popped at edge t appears on X during cycle t..t+1.
    - Popped entry with last=1 → next state IDLE after that sample is driven.
    - FIFO empty with no last seen → UNDERRUN.
  - UNDERRUN: x_valid=0, X holds the last driven sample; set underrun=1; win_cnt=0. Return to STREAM when occupancy>=PRIME_LVL or a last entry is present.
- win_cnt (4 bits, saturates at WIN):
  - Increments on each cycle with x_valid=1.
  - Cleared on entering IDLE or UNDERRUN, and on any cycle with x_valid=0.
- y_valid is registered and is 1 in the cycle after a cycle in which x_valid=1 and win_cnt+1>=WIN. This aligns with the filter registering the sample one edge later.
  - Example: for a frame of N>=9 samples, y_valid is high for N-8 consecutive cycles.
- underrun stays 1 until reset; a new frame does not clear it.
- Arithmetic: occupancy uses log2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.
- Back-to-back frames:
  - If the next frame's first entry is already in the FIFO when last is popped, the block still spends ≥1 cycle in IDLE (x_valid=0), which breaks the window.
  - It then re-primes per PRIME_LVL.
- Reset mid-frame: everything returns to reset values at that edge; FIFO contents are discarded.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 → in_ready=0 is not required, but no push occurs; after release all outputs 0 and in_ready=1.
- Frame of 12 samples (10,20,...,120), in_last on 120, continuous push → streaming starts once 4 are buffered; X shows 10..120 on 12 consecutive x_valid cycles; y_valid high for exactly 4 cycles, starting the cycle after X=90; then IDLE with X=0.
- Short frame of 3 samples with in_last on the 3rd (PRIME_LVL=4) → streams all 3 immediately; y_valid never asserts; busy drops after.
- Underrun: push 5 samples, then stall 6 cycles, then push 10 more with last → after 5 samples x_valid=0, X holds sample 5, underrun=1, win_cnt restarts; y_valid asserts only after 9 post-resume samples, i.e. 2 cycles.
- Full FIFO: push 20 samples while the consumer has not started (PRIME_LVL=16) → in_ready drops at occupancy 16; exactly 16 accepted; the remaining 4 are accepted as streaming drains; no loss or duplication in X order.
- Reset asserted mid-STREAM at sample 7 of 12 → next cycle x_valid=0, FIFO empty, win_cnt=0; a fresh 9-sample frame then gives exactly one y_valid cycle.
